ext_bus_arbiter: RTL and testbench
==================================

# ext_bus_arbiter

Sequencer and arbiter for the shared external memory bus: cartridge/RAM address, data pins, n_read/n_write. Three requesters share the bus: OAM DMA, the CPU port (stallable), and the UART debugger memory port. Each gets a req/gnt handshake. The block drives one bus access at a time, holds each access for a fixed number of clocks, and inserts a data-bus turnaround cycle after writes. Its outputs feed the pad registers and the MBC address translator; its read data returns to the winning requester.

## Interface
Parameters:
- ACCESS_CYCLES, 2: clocks ext_rd/ext_wr stay asserted per access; legal 1..15.
- STARVE_LIMIT, 15: consecutive denied cycles after which the debugger gets top priority; legal 1..255.

Ports:
- clk  in  1  bus clock (gbclk domain).
- reset  in  1  synchronous, active-high.
- dma_req, cpu_req, dbg_req  in  1 each  access request; level, held until gnt.
- dma_we, cpu_we, dbg_we  in  1 each  1 = write, 0 = read.
- dma_adr, cpu_adr, dbg_adr  in  16 each  address.
- dma_wdata, cpu_wdata, dbg_wdata  in  8 each  write data.
- dma_gnt, cpu_gnt, dbg_gnt  out  1 each  one-cycle accept pulse.
- dma_rvalid, cpu_rvalid, dbg_rvalid  out  1 each  one-cycle read-data-valid pulse.
- rdata  out  8  read data, shared by all requesters.
- ext_adr  out  16  bus address.
- ext_dout  out  8  bus write data.
- ext_rd  out  1  read strobe.
- ext_wr  out  1  write strobe.
- ext_oe  out  1  data pin output enable.
- ext_din  in  8  data pins.
- owner  out  2  current bus owner: 0 none, 1 dma, 2 cpu, 3 dbg.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ACCESS, TURN.
- **Grant windows.** A grant is possible only in:
  - IDLE;
  - TURN;
  - the last ACCESS cycle of a read (back-to-back reads).
- **Granting.** In a grant window with at least one req high:
  - exactly one gnt pulses, combinationally in that cycle;
  - adr/we/wdata of the winner are latched at that edge;
  - next state is ACCESS with the cycle counter loaded to ACCESS_CYCLES.
- **Withdrawal.** A requester may drop req before gnt. No side effects.
- **Priority.** DMA > CPU > DBG.
  - starve counter (8 bit, saturating) increments each cycle dbg_req=1 and dbg_gnt=0;
  - it clears on dbg_gnt or when dbg_req=0;
  - while starve >= STARVE_LIMIT, DBG outranks both DMA and CPU.
- **ACCESS.**
  - ext_adr and ext_dout come from registered latched values; owner = winner.
  - ext_rd = !we, ext_wr = we, ext_oe = we.
  - The counter decrements each cycle.
  - On the last cycle of a read, ext_din is registered into rdata and the owner's rvalid pulses the next cycle.
  - Exit from the last cycle: a write goes to TURN. A read goes to ACCESS if a new grant is made, otherwise to IDLE.
- **TURN.** Exactly 1 cycle.
  - ext_wr=0, ext_rd=0, ext_oe=1 (data held); ext_adr and ext_dout are held.
  - Next state is ACCESS if a grant is made, else IDLE.
- **IDLE.**
  - ext_rd, ext_wr and ext_oe are 0; owner=0.
  - ext_adr, ext_dout and rdata hold their last values.
- **Reset** (any state, including mid-access):
  - next cycle: IDLE;
  - ext_rd, ext_wr, ext_oe, all gnt and all rvalid = 0;
  - ext_adr=0, ext_dout=0, rdata=0xFF, owner=0, starve=0;
  - a pending rvalid is dropped.
- ext_rd and ext_wr are never high together. ext_oe=0 whenever ext_rd=1.

## Timing
Let A = ACCESS_CYCLES and let gnt be in cycle N.
- **Read:** ext_rd high during N+1..N+A. ext_din is sampled at the end of N+A. rvalid and rdata are valid in N+A+1.
- **Write:** ext_wr high during N+1..N+A. ext_oe high during N+1..N+A+1 (TURN). The earliest next gnt is cycle N+A+1, so its access starts at N+A+2.
- **Back-to-back reads:** the next gnt is in N+A. Bus utilisation is 100%, with no idle cycle between reads.
- **Timing paths:** gnt depends combinationally on req and state. All ext_* outputs, owner and rdata are registered.
- **Simultaneous events:**
  - gnt and a req drop in the same cycle: the grant stands.
  - All three req rise together: DMA wins, CPU next, DBG last (unless starved).

## Test plan
- **Single CPU read, A=2.** cpu_req, we=0, adr=0x4000, ext_din=0x5A. Expect cpu_gnt in cycle N, ext_rd in N+1..N+2, then cpu_rvalid with rdata=0x5A in N+3. owner=2 during ACCESS.
- **CPU write then DMA read, A=1.** Expect ext_wr in N+1 and ext_oe in N+1..N+2 (TURN). dma_gnt no earlier than N+2; ext_rd only at N+3, with ext_oe=0.
- **Priority.** All three requesting reads. Grant order: DMA, CPU, DBG, with back-to-back reads and no IDLE gap.
- **Starvation, STARVE_LIMIT=4.** CPU requests continuously and DBG is held. Expect dbg_gnt in the first grant window after 4 denied cycles. The counter is 0 after that gnt.
- **Reset mid-access.** Assert reset in the second ACCESS cycle of a read. Next cycle: IDLE, ext_rd=0, rdata=0xFF, and no rvalid ever for that read.
- **A=15, alternating write/read stream.** Check ext_rd and ext_wr are never both high, ext_oe never overlaps ext_rd, and each access lasts exactly 15 cycles.

Source files
------------

// File: rtl/ext_bus_arbiter_if.sv
// Requester handshakes and external memory pin bundle for ext_bus_arbiter.
// The slave side is the arbiter. The master side is requesters plus pads.
interface ext_bus_arbiter_if;
  logic        dma_req,   cpu_req,   dbg_req;
  logic        dma_we,    cpu_we,    dbg_we;
  logic [15:0] dma_adr,   cpu_adr,   dbg_adr;
  logic [7:0]  dma_wdata, cpu_wdata, dbg_wdata;
  logic        dma_gnt,   cpu_gnt,   dbg_gnt;
  logic        dma_rvalid, cpu_rvalid, dbg_rvalid;
  logic [7:0]  rdata;
  logic [15:0] ext_adr;
  logic [7:0]  ext_dout;
  logic        ext_rd;
  logic        ext_wr;
  logic        ext_oe;
  logic [7:0]  ext_din;
  logic [1:0]  owner;
  logic        busy;

  modport slave (
    input  dma_req, cpu_req, dbg_req,
    input  dma_we, cpu_we, dbg_we,
    input  dma_adr, cpu_adr, dbg_adr,
    input  dma_wdata, cpu_wdata, dbg_wdata,
    input  ext_din,
    output dma_gnt, cpu_gnt, dbg_gnt,
    output dma_rvalid, cpu_rvalid, dbg_rvalid,
    output rdata, ext_adr, ext_dout, ext_rd, ext_wr, ext_oe, owner, busy
  );

  modport master (
    output dma_req, cpu_req, dbg_req,
    output dma_we, cpu_we, dbg_we,
    output dma_adr, cpu_adr, dbg_adr,
    output dma_wdata, cpu_wdata, dbg_wdata,
    output ext_din,
    input  dma_gnt, cpu_gnt, dbg_gnt,
    input  dma_rvalid, cpu_rvalid, dbg_rvalid,
    input  rdata, ext_adr, ext_dout, ext_rd, ext_wr, ext_oe, owner, busy
  );
endinterface

// File: rtl/ext_bus_arbiter.sv
// External memory bus sequencer. It arbitrates DMA, CPU and debugger requests.
// Each access is fixed-length, and a turnaround cycle follows every write.
module ext_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 15
) (
  input logic              clk,
  input logic              reset,
  ext_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [1:0]  own_q;
  logic [7:0]  starve;

  logic        last;
  logic        window;
  logic        starved;
  logic [1:0]  sel;
  logic        sel_we;
  logic [15:0] sel_adr;
  logic [7:0]  sel_wdata;

  assign last    = (state == ACCESS) && (cnt == 4'd1);
  assign window  = (state == IDLE) || (state == TURN) || (last && !we_q);
  assign starved = (32'(starve) >= STARVE_LIMIT);

  // The winner is encoded the same way as owner: 1 dma, 2 cpu, 3 dbg.
  always_comb begin
    sel       = 2'd0;
    sel_we    = 1'b0;
    sel_adr   = '0;
    sel_wdata = '0;
    if (window && !reset) begin
      if (bus.dbg_req && starved)  sel = 2'd3;
      else if (bus.dma_req)        sel = 2'd1;
      else if (bus.cpu_req)        sel = 2'd2;
      else if (bus.dbg_req)        sel = 2'd3;
    end
    unique case (sel)
      2'd1:    begin sel_we = bus.dma_we; sel_adr = bus.dma_adr; sel_wdata = bus.dma_wdata; end
      2'd2:    begin sel_we = bus.cpu_we; sel_adr = bus.cpu_adr; sel_wdata = bus.cpu_wdata; end
      2'd3:    begin sel_we = bus.dbg_we; sel_adr = bus.dbg_adr; sel_wdata = bus.dbg_wdata; end
      default: begin end
    endcase
  end

  assign bus.dma_gnt = (sel == 2'd1);
  assign bus.cpu_gnt = (sel == 2'd2);
  assign bus.dbg_gnt = (sel == 2'd3);
  assign bus.busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      we_q           <= 1'b0;
      own_q          <= '0;
      starve         <= '0;
      bus.ext_adr    <= '0;
      bus.ext_dout   <= '0;
      bus.ext_rd     <= 1'b0;
      bus.ext_wr     <= 1'b0;
      bus.ext_oe     <= 1'b0;
      bus.owner      <= '0;
      bus.rdata      <= '1;
      bus.dma_rvalid <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dbg_rvalid <= 1'b0;
    end else begin
      bus.dma_rvalid <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dbg_rvalid <= 1'b0;

      if (bus.dbg_req && (sel != 2'd3))
        starve <= (starve == 8'hFF) ? starve : starve + 8'd1;
      else
        starve <= '0;

      // Read completion uses the old owner, even when a new grant takes this edge.
      if (last && !we_q) begin
        bus.rdata <= bus.ext_din;
        unique case (own_q)
          2'd1:    bus.dma_rvalid <= 1'b1;
          2'd2:    bus.cpu_rvalid <= 1'b1;
          2'd3:    bus.dbg_rvalid <= 1'b1;
          default: begin end
        endcase
      end

      if (sel != 2'd0) begin
        state        <= ACCESS;
        cnt          <= 4'(ACCESS_CYCLES);
        we_q         <= sel_we;
        own_q        <= sel;
        bus.ext_adr  <= sel_adr;
        bus.ext_dout <= sel_wdata;
        bus.ext_rd   <= !sel_we;
        bus.ext_wr   <= sel_we;
        bus.ext_oe   <= sel_we;
        bus.owner    <= sel;
      end else begin
        unique case (state)
          ACCESS: begin
            if (!last) begin
              cnt <= cnt - 4'd1;
            end else if (we_q) begin
              // Keep the pins driven for one cycle after the write strobe drops.
              state      <= TURN;
              bus.ext_wr <= 1'b0;
              bus.ext_oe <= 1'b1;
            end else begin
              state      <= IDLE;
              bus.ext_rd <= 1'b0;
              bus.owner  <= '0;
            end
          end
          TURN: begin
            state      <= IDLE;
            bus.ext_oe <= 1'b0;
            bus.owner  <= '0;
          end
          default: begin end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter. Three instances cover A=2, A=1 with STARVE_LIMIT=4, and A=15.
module tb_ext_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ext_bus_arbiter_if b2();
  ext_bus_arbiter_if b1();
  ext_bus_arbiter_if b15();

  ext_bus_arbiter #(.ACCESS_CYCLES(2),  .STARVE_LIMIT(15)) u_a2  (.clk(clk), .reset(reset), .bus(b2.slave));
  ext_bus_arbiter #(.ACCESS_CYCLES(1),  .STARVE_LIMIT(4))  u_a1  (.clk(clk), .reset(reset), .bus(b1.slave));
  ext_bus_arbiter #(.ACCESS_CYCLES(15), .STARVE_LIMIT(15)) u_a15 (.clk(clk), .reset(reset), .bus(b15.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    b2.dma_req = 0;  b2.cpu_req = 0;  b2.dbg_req = 0;
    b2.dma_we = 0;   b2.cpu_we = 0;   b2.dbg_we = 0;
    b2.dma_adr = 0;  b2.cpu_adr = 0;  b2.dbg_adr = 0;
    b2.dma_wdata = 0; b2.cpu_wdata = 0; b2.dbg_wdata = 0; b2.ext_din = 0;
    b1.dma_req = 0;  b1.cpu_req = 0;  b1.dbg_req = 0;
    b1.dma_we = 0;   b1.cpu_we = 0;   b1.dbg_we = 0;
    b1.dma_adr = 0;  b1.cpu_adr = 0;  b1.dbg_adr = 0;
    b1.dma_wdata = 0; b1.cpu_wdata = 0; b1.dbg_wdata = 0; b1.ext_din = 0;
    b15.dma_req = 0; b15.cpu_req = 0; b15.dbg_req = 0;
    b15.dma_we = 0;  b15.cpu_we = 0;  b15.dbg_we = 0;
    b15.dma_adr = 0; b15.cpu_adr = 0; b15.dbg_adr = 0;
    b15.dma_wdata = 0; b15.cpu_wdata = 0; b15.dbg_wdata = 0; b15.ext_din = 0;
  endtask

  initial begin
    int len;
    int viol;
    logic got;
    logic wr_access;

    reset = 1'b1;
    clear_all();
    tick();
    tick();
    check("rst_adr",   b2.ext_adr, 16'h0000);
    check("rst_dout",  b2.ext_dout, 8'h00);
    check("rst_rdata", b2.rdata, 8'hFF);
    check("rst_owner", b2.owner, 2'd0);
    check("rst_busy",  b2.busy, 1'b0);
    check("rst_rd",    b2.ext_rd, 1'b0);
    check("rst_oe",    b1.ext_oe, 1'b0);
    check("rst_gnt",   b2.cpu_gnt, 1'b0);
    reset = 1'b0;
    tick();

    // Single CPU read, A=2
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_adr = 16'h4000; b2.ext_din = 8'h5A;
    #1;
    check("t1_cpu_gnt", b2.cpu_gnt, 1'b1);
    check("t1_dma_gnt", b2.dma_gnt, 1'b0);
    tick();
    b2.cpu_req = 0;
    check("t1_rd_n1",    b2.ext_rd, 1'b1);
    check("t1_adr_n1",   b2.ext_adr, 16'h4000);
    check("t1_owner_n1", b2.owner, 2'd2);
    check("t1_oe_n1",    b2.ext_oe, 1'b0);
    check("t1_gnt_n1",   b2.cpu_gnt, 1'b0);
    tick();
    check("t1_rd_n2",     b2.ext_rd, 1'b1);
    check("t1_rvalid_n2", b2.cpu_rvalid, 1'b0);
    tick();
    check("t1_rvalid_n3", b2.cpu_rvalid, 1'b1);
    check("t1_rdata_n3",  b2.rdata, 8'h5A);
    check("t1_rd_n3",     b2.ext_rd, 1'b0);
    check("t1_owner_n3",  b2.owner, 2'd0);
    check("t1_busy_n3",   b2.busy, 1'b0);
    tick();
    check("t1_rvalid_n4", b2.cpu_rvalid, 1'b0);
    check("t1_rdata_n4",  b2.rdata, 8'h5A);

    // CPU write then DMA read, A=1
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_adr = 16'h8000; b1.cpu_wdata = 8'h3C;
    #1;
    check("t2_cpu_gnt", b1.cpu_gnt, 1'b1);
    tick();
    b1.cpu_req = 0;
    b1.dma_req = 1; b1.dma_we = 0; b1.dma_adr = 16'h1234; b1.ext_din = 8'hA7;
    check("t2_wr_n1",   b1.ext_wr, 1'b1);
    check("t2_rd_n1",   b1.ext_rd, 1'b0);
    check("t2_oe_n1",   b1.ext_oe, 1'b1);
    check("t2_dout_n1", b1.ext_dout, 8'h3C);
    check("t2_adr_n1",  b1.ext_adr, 16'h8000);
    #1;
    check("t2_dma_gnt_n1", b1.dma_gnt, 1'b0);
    tick();
    check("t2_wr_n2",  b1.ext_wr, 1'b0);
    check("t2_rd_n2",  b1.ext_rd, 1'b0);
    check("t2_oe_n2",  b1.ext_oe, 1'b1);
    check("t2_adr_n2", b1.ext_adr, 16'h8000);
    check("t2_busy_n2", b1.busy, 1'b1);
    #1;
    check("t2_dma_gnt_n2", b1.dma_gnt, 1'b1);
    tick();
    b1.dma_req = 0;
    check("t2_rd_n3",    b1.ext_rd, 1'b1);
    check("t2_oe_n3",    b1.ext_oe, 1'b0);
    check("t2_wr_n3",    b1.ext_wr, 1'b0);
    check("t2_adr_n3",   b1.ext_adr, 16'h1234);
    check("t2_owner_n3", b1.owner, 2'd1);
    tick();
    check("t2_rvalid_n4", b1.dma_rvalid, 1'b1);
    check("t2_rdata_n4",  b1.rdata, 8'hA7);
    check("t2_rd_n4",     b1.ext_rd, 1'b0);

    // Priority with back-to-back reads, A=1
    b1.dma_req = 1; b1.dma_we = 0; b1.dma_adr = 16'h0100;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_adr = 16'h0200;
    b1.dbg_req = 1; b1.dbg_we = 0; b1.dbg_adr = 16'h0300;
    #1;
    check("t3_dma_gnt", b1.dma_gnt, 1'b1);
    check("t3_cpu_gnt0", b1.cpu_gnt, 1'b0);
    check("t3_dbg_gnt0", b1.dbg_gnt, 1'b0);
    tick();
    b1.dma_req = 0; b1.ext_din = 8'h11;
    check("t3_owner_dma", b1.owner, 2'd1);
    check("t3_adr_dma",   b1.ext_adr, 16'h0100);
    #1;
    check("t3_cpu_gnt", b1.cpu_gnt, 1'b1);
    check("t3_dbg_gnt1", b1.dbg_gnt, 1'b0);
    tick();
    b1.cpu_req = 0; b1.ext_din = 8'h22;
    check("t3_owner_cpu", b1.owner, 2'd2);
    check("t3_adr_cpu",   b1.ext_adr, 16'h0200);
    check("t3_rd_cpu",    b1.ext_rd, 1'b1);
    check("t3_dma_rvalid", b1.dma_rvalid, 1'b1);
    check("t3_rdata_dma", b1.rdata, 8'h11);
    #1;
    check("t3_dbg_gnt", b1.dbg_gnt, 1'b1);
    tick();
    b1.dbg_req = 0; b1.ext_din = 8'h33;
    check("t3_owner_dbg", b1.owner, 2'd3);
    check("t3_busy_dbg",  b1.busy, 1'b1);
    check("t3_cpu_rvalid", b1.cpu_rvalid, 1'b1);
    check("t3_rdata_cpu", b1.rdata, 8'h22);
    tick();
    check("t3_dbg_rvalid", b1.dbg_rvalid, 1'b1);
    check("t3_rdata_dbg",  b1.rdata, 8'h33);
    check("t3_owner_end",  b1.owner, 2'd0);
    tick();

    // Starvation, STARVE_LIMIT=4
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_adr = 16'h0400;
    b1.dbg_req = 1; b1.dbg_we = 0; b1.dbg_adr = 16'h0500;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_cpu_gnt%0d", i), b1.cpu_gnt, 1'b1);
      check($sformatf("t4_dbg_gnt%0d", i), b1.dbg_gnt, 1'b0);
      tick();
    end
    #1;
    check("t4_dbg_gnt_starved", b1.dbg_gnt, 1'b1);
    check("t4_cpu_gnt_starved", b1.cpu_gnt, 1'b0);
    tick();
    check("t4_owner_dbg", b1.owner, 2'd3);
    check("t4_starve_cleared", u_a1.starve, 8'd0);
    #1;
    check("t4_cpu_gnt_after", b1.cpu_gnt, 1'b1);
    check("t4_dbg_gnt_after", b1.dbg_gnt, 1'b0);
    tick();
    b1.cpu_req = 0; b1.dbg_req = 0;
    tick();
    tick();

    // Reset in the second ACCESS cycle of a read, A=2
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_adr = 16'h5555; b2.ext_din = 8'h99;
    #1;
    check("t5_cpu_gnt", b2.cpu_gnt, 1'b1);
    tick();
    b2.cpu_req = 0;
    check("t5_rd_n1", b2.ext_rd, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy",   b2.busy, 1'b0);
    check("t5_rd",     b2.ext_rd, 1'b0);
    check("t5_rdata",  b2.rdata, 8'hFF);
    check("t5_rvalid", b2.cpu_rvalid, 1'b0);
    check("t5_owner",  b2.owner, 2'd0);
    check("t5_adr",    b2.ext_adr, 16'h0000);
    tick();
    check("t5_rvalid_late1", b2.cpu_rvalid, 1'b0);
    tick();
    check("t5_rvalid_late2", b2.cpu_rvalid, 1'b0);

    // A=15 alternating write/read stream
    viol = 0;
    b15.ext_din = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      wr_access     = (k % 2 == 0);
      b15.cpu_req   = 1;
      b15.cpu_we    = wr_access;
      b15.cpu_adr   = 16'hA000 + 16'(k);
      b15.cpu_wdata = 8'(8'h40 + k);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        #1;
        if (b15.cpu_gnt) got = 1'b1;
        else tick();
      end
      check($sformatf("t6_gnt%0d", k), got, 1'b1);
      tick();
      b15.cpu_req = 0;
      len = 0;
      for (int c = 0; c < 40 && (b15.ext_rd || b15.ext_wr); c++) begin
        if (b15.ext_rd && b15.ext_wr) viol++;
        if (b15.ext_rd && b15.ext_oe) viol++;
        len++;
        tick();
      end
      check($sformatf("t6_len%0d", k), len, 15);
      check($sformatf("t6_oe_after%0d", k), b15.ext_oe, wr_access);
    end
    check("t6_overlap", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
